fft8_loader: RTL and testbench

Input framing and sequencing stage that sits directly upstream of the 8-point FFT core. It accepts a serial stream of complex samples with a valid/ready handshake and assembles eight samples into stable frame registers that drive the core's parallel `xr0..xr7` / `xi0..xi7` inputs. It then sweeps the core's `sel` input 0..7 and emits `out_valid`/`out_last` aligned with the core's registered `yr`/`yi`, so downstream logic sees a bin-ordered output stream.

---
 rtl/fft8_pkg.sv | 14 +
 rtl/fft8_loader.sv | 159 +++++++++++++++
 tb/tb_fft8_loader.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fft8_pkg.sv
// Shared constants and types for the 8-point FFT front end.
package fft8_pkg;

    localparam int N_PTS     = 8;
    localparam int LOG2_N    = 3;
    localparam int DEFAULT_W = 8;

    // Loader phases: collect a frame, then sweep the core's bin select.
    typedef enum logic {
        FILL  = 1'b0,
        SWEEP = 1'b1
    } state_t;

endpackage

// File: rtl/fft8_loader.sv
// Serial-to-parallel framing stage in front of the 8-point FFT core.
// Collects eight complex samples into stable frame registers, then steps
// the core's bin select 0..7 and flags which core output cycles are valid.
// The core itself uses an active-high synchronous reset, so whoever wires
// the two together feeds it with the inverse of this block's rst.
module fft8_loader
    import fft8_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        in_re,
    input  logic [W-1:0]        in_im,
    input  logic                in_last,
    output logic [W-1:0]        xr0,
    output logic [W-1:0]        xr1,
    output logic [W-1:0]        xr2,
    output logic [W-1:0]        xr3,
    output logic [W-1:0]        xr4,
    output logic [W-1:0]        xr5,
    output logic [W-1:0]        xr6,
    output logic [W-1:0]        xr7,
    output logic [W-1:0]        xi0,
    output logic [W-1:0]        xi1,
    output logic [W-1:0]        xi2,
    output logic [W-1:0]        xi3,
    output logic [W-1:0]        xi4,
    output logic [W-1:0]        xi5,
    output logic [W-1:0]        xi6,
    output logic [W-1:0]        xi7,
    output logic [LOG2_N-1:0]   sel,
    output logic                out_valid,
    output logic                out_last,
    output logic                frame_err
);

    localparam logic [LOG2_N-1:0] LAST_IDX = LOG2_N'(N_PTS - 1);

    state_t             state_q;
    state_t             state_d;
    logic [LOG2_N-1:0]  cnt_q;
    logic [LOG2_N-1:0]  cnt_d;
    logic [LOG2_N-1:0]  sel_q;
    logic [LOG2_N-1:0]  sel_d;
    logic               ready_q;
    logic               valid_q;
    logic               last_q;
    logic               err_q;
    logic               err_d;
    logic               wr_en;
    logic               accept;

    logic [W-1:0]       xr_q [N_PTS];
    logic [W-1:0]       xi_q [N_PTS];

    // ready_q is only ever high in FILL, so it alone qualifies an accept
    assign accept = in_valid && ready_q;

    // Next-state logic: slot bookkeeping, in_last check and the sel sweep
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        wr_en   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            FILL: begin
                if (accept) begin
                    if (in_last != (cnt_q == LAST_IDX)) begin
                        err_d = 1'b1;
                        cnt_d = '0;
                    end else if (cnt_q == LAST_IDX) begin
                        wr_en   = 1'b1;
                        state_d = SWEEP;
                        cnt_d   = '0;
                        sel_d   = '0;
                    end else begin
                        wr_en = 1'b1;
                        cnt_d = cnt_q + LOG2_N'(1);
                    end
                end
            end
            SWEEP: begin
                if (sel_q == LAST_IDX) begin
                    state_d = FILL;
                    sel_d   = '0;
                end else begin
                    sel_d = sel_q + LOG2_N'(1);
                end
            end
            default: begin
                state_d = FILL;
                cnt_d   = '0;
                sel_d   = '0;
            end
        endcase
    end

    // Control registers; out flags trail the sweep by one cycle to line up with the core's registered output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
            sel_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            ready_q <= (state_d == FILL);
            valid_q <= (state_q == SWEEP);
            last_q  <= (state_q == SWEEP) && (sel_q == LAST_IDX);
            err_q   <= err_d;
        end
    end

    // Frame registers: written in natural order while filling, frozen during the sweep
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_PTS; i++) begin
                xr_q[i] <= '0;
                xi_q[i] <= '0;
            end
        end else if (wr_en) begin
            xr_q[cnt_q] <= in_re;
            xi_q[cnt_q] <= in_im;
        end
    end

    assign in_ready  = ready_q;
    assign sel       = sel_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign frame_err = err_q;

    assign xr0 = xr_q[0];
    assign xr1 = xr_q[1];
    assign xr2 = xr_q[2];
    assign xr3 = xr_q[3];
    assign xr4 = xr_q[4];
    assign xr5 = xr_q[5];
    assign xr6 = xr_q[6];
    assign xr7 = xr_q[7];
    assign xi0 = xi_q[0];
    assign xi1 = xi_q[1];
    assign xi2 = xi_q[2];
    assign xi3 = xi_q[3];
    assign xi4 = xi_q[4];
    assign xi5 = xi_q[5];
    assign xi6 = xi_q[6];
    assign xi7 = xi_q[7];

endmodule

// File: tb/tb_fft8_loader.sv
// Self-checking bench for fft8_loader: directed frames, a scoreboard of
// expected output beats, and a monitor that pops one entry per out_valid.
module tb_fft8_loader;
    import fft8_pkg::*;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_last = 1'b0;
    logic [W-1:0]   in_re = '0;
    logic [W-1:0]   in_im = '0;
    logic           in_ready;
    logic [W-1:0]   xr0, xr1, xr2, xr3, xr4, xr5, xr6, xr7;
    logic [W-1:0]   xi0, xi1, xi2, xi3, xi4, xi5, xi6, xi7;
    logic [2:0]     sel;
    logic           out_valid;
    logic           out_last;
    logic           frame_err;

    logic [8*W-1:0] xr_all;
    logic [8*W-1:0] xi_all;

    typedef struct {
        logic [2:0]     bin;
        logic           last;
        logic [8*W-1:0] xr;
        logic [8*W-1:0] xi;
    } beat_t;

    beat_t      exp_q[$];
    int         tests = 0;
    int         fails = 0;
    int         beats = 0;
    int         err_cycles = 0;
    logic [2:0] sel_prev = '0;

    assign xr_all = {xr7, xr6, xr5, xr4, xr3, xr2, xr1, xr0};
    assign xi_all = {xi7, xi6, xi5, xi4, xi3, xi2, xi1, xi0};

    fft8_loader #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .in_last   (in_last),
        .xr0       (xr0),
        .xr1       (xr1),
        .xr2       (xr2),
        .xr3       (xr3),
        .xr4       (xr4),
        .xr5       (xr5),
        .xr6       (xr6),
        .xr7       (xr7),
        .xi0       (xi0),
        .xi1       (xi1),
        .xi2       (xi2),
        .xi3       (xi3),
        .xi4       (xi4),
        .xi5       (xi5),
        .xi6       (xi6),
        .xi7       (xi7),
        .sel       (sel),
        .out_valid (out_valid),
        .out_last  (out_last),
        .frame_err (frame_err)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every out_valid beat must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst) begin
            if (frame_err) err_cycles++;
            if (out_valid) begin
                beats++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_beat: out_valid=1 with sel_prev=%0d, expected no beat", sel_prev);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check_output("beat_bin_sel", 64'(sel_prev), 64'(e.bin));
                    check_output("beat_out_last", 64'(out_last), 64'(e.last));
                    check_output("beat_xr", xr_all, e.xr);
                    check_output("beat_xi", xi_all, e.xi);
                end
            end
        end
        sel_prev = sel;
    end

    // One sample handshake; entered and left on a negedge
    task automatic send_sample(input logic [W-1:0] re, input logic [W-1:0] im,
                               input logic last, input bit gap);
        int n;
        in_valid = 1'b1;
        in_re    = re;
        in_im    = im;
        in_last  = last;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("[TB] FAIL ready_timeout: in_ready=%0b after %0d cycles, expected 1", in_ready, n);
        end
        @(posedge clk);
        @(negedge clk);
        if (gap) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    // A well-formed frame plus its eight expected output beats
    task automatic send_frame(input logic [8*W-1:0] re_v, input logic [8*W-1:0] im_v, input bit gap);
        for (int i = 0; i < 8; i++)
            send_sample(re_v[i*W +: W], im_v[i*W +: W], i == 7, gap);
        for (int k = 0; k < 8; k++) begin
            beat_t b;
            b.bin  = 3'(k);
            b.last = (k == 7);
            b.xr   = re_v;
            b.xi   = im_v;
            exp_q.push_back(b);
        end
    endtask

    task automatic idle(input int cycles);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        int n;
        int low_cnt;
        int beats_before;

        // reset held three cycles
        repeat (3) @(negedge clk);
        check_output("rst_in_ready", 64'(in_ready), 64'd0);
        check_output("rst_sel", 64'(sel), 64'd0);
        check_output("rst_out_valid", 64'(out_valid), 64'd0);
        check_output("rst_out_last", 64'(out_last), 64'd0);
        check_output("rst_frame_err", 64'(frame_err), 64'd0);
        check_output("rst_xr", xr_all, 64'd0);
        check_output("rst_xi", xi_all, 64'd0);
        rst = 1'b1;
        #1;
        check_output("release_ready_before_edge", 64'(in_ready), 64'd0);
        @(negedge clk);
        check_output("release_ready_after_edge", 64'(in_ready), 64'd1);

        // impulse frame, back-to-back samples
        send_frame(64'h0000_0000_0000_0001, 64'h0, 1'b0);
        check_output("sweep_sel0_after_accept", 64'(sel), 64'd0);
        check_output("sweep_ready_low", 64'(in_ready), 64'd0);
        idle(12);
        check_output("impulse_drained", 64'(exp_q.size()), 64'd0);
        check_output("impulse_beats", 64'(beats), 64'd8);

        // DC frame with in_valid toggling
        send_frame(64'h0101_0101_0101_0101, 64'h0, 1'b1);
        idle(12);
        check_output("dc_drained", 64'(exp_q.size()), 64'd0);
        check_output("dc_no_err", 64'(err_cycles), 64'd0);

        // early in_last on the 5th sample
        beats_before = beats;
        for (int i = 0; i < 5; i++)
            send_sample(8'(i + 16), 8'(i + 32), i == 4, 1'b0);
        idle(12);
        check_output("early_last_err", 64'(err_cycles), 64'd1);
        check_output("early_last_no_sweep", 64'(beats), 64'(beats_before));
        check_output("early_last_ready", 64'(in_ready), 64'd1);
        send_frame(64'h0807_0605_0403_0201, 64'hF8F9_FAFB_FCFD_FEFF, 1'b0);
        idle(12);
        check_output("recover_drained", 64'(exp_q.size()), 64'd0);

        // missing in_last on the 8th sample
        beats_before = beats;
        for (int i = 0; i < 8; i++)
            send_sample(8'(i + 64), 8'(i + 80), 1'b0, 1'b0);
        idle(20);
        check_output("missing_last_err", 64'(err_cycles), 64'd2);
        check_output("missing_last_no_valid", 64'(beats), 64'(beats_before));
        check_output("missing_last_ready", 64'(in_ready), 64'd1);

        // reset in the middle of a sweep
        send_frame(64'h7F80_7F80_1234_5678, 64'h1122_3344_5566_7788, 1'b0);
        n = 0;
        while (sel != 3'd4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_output("reached_sel4", 64'(sel), 64'd4);
        rst = 1'b0;
        #1;
        exp_q.delete();
        check_output("midrst_out_valid", 64'(out_valid), 64'd0);
        check_output("midrst_sel", 64'(sel), 64'd0);
        check_output("midrst_xr", xr_all, 64'd0);
        check_output("midrst_xi", xi_all, 64'd0);
        check_output("midrst_in_ready", 64'(in_ready), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // back-to-back frames with in_valid held high
        fork
            begin
                send_frame(64'h0102_0304_0506_0708, 64'h1, 1'b0);
                send_frame(64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1'b0);
                send_frame(64'hFFFE_FDFC_FBFA_F9F8, 64'h0, 1'b0);
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            begin
                n = 0;
                while (in_ready && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                low_cnt = 0;
                for (int c = 0; c < 32; c++) begin
                    if (!in_ready) low_cnt++;
                    @(negedge clk);
                end
                check_output("b2b_ready_low_cycles", 64'(low_cnt), 64'd16);
            end
        join
        idle(14);
        check_output("b2b_drained", 64'(exp_q.size()), 64'd0);
        check_output("final_err_count", 64'(err_cycles), 64'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
